// File: rtl/response_framer_if.sv
// Request, payload and transmit handshake bundle for response_framer.
// The master modport is the framer side; slave is the host/peripheral/CDC side.
interface response_framer_if;
  logic       rsp_req;
  logic       rsp_ready;
  logic [2:0] rsp_periph;
  logic [4:0] rsp_opcode;
  logic [7:0] rsp_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       len_error;

  modport master (
    input  rsp_req, rsp_periph, rsp_opcode, rsp_len, pay_data, pay_valid, tx_ready,
    output rsp_ready, pay_ready, tx_data, tx_valid, busy, frame_done, len_error
  );

  modport slave (
    output rsp_req, rsp_periph, rsp_opcode, rsp_len, pay_data, pay_valid, tx_ready,
    input  rsp_ready, pay_ready, tx_data, tx_valid, busy, frame_done, len_error
  );
endinterface

// File: rtl/response_framer.sv
// Builds reply frames 5A, cmd, len, payload[, checksum] onto a valid/ready byte stream.
// Define RSP_CHECKSUM_EN to append the 8-bit additive checksum byte.
module response_framer #(
  parameter int MAX_PAYLOAD_LEN = 64
) (
  input logic              clk,
  input logic              rst_n,
  response_framer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CMD, S_LEN, S_PAY, S_SUM, S_DONE} state_t;

`ifdef RSP_CHECKSUM_EN
  localparam state_t S_PAY_END = S_SUM;
`else
  localparam state_t S_PAY_END = S_DONE;
`endif

  state_t     r_state, w_next;
  logic [7:0] r_cmd, r_len, r_cnt, r_tx_data;
  logic       r_tx_valid, r_len_error;
`ifdef RSP_CHECKSUM_EN
  logic [7:0] r_sum;
`endif
  logic       w_loadable, w_load, w_accept, w_reject, w_pay_ready;
  logic [7:0] w_byte, w_cnt_nxt;

  // Output register may take a new byte when empty or being drained this cycle.
  assign w_loadable  = !r_tx_valid || bus.tx_ready;
  assign w_pay_ready = (r_state == S_PAY) && w_loadable;
  assign w_cnt_nxt   = r_cnt + 8'd1;
  assign w_reject    = bus.rsp_req && (r_state == S_IDLE) && (bus.rsp_len >  8'(MAX_PAYLOAD_LEN));
  assign w_accept    = bus.rsp_req && (r_state == S_IDLE) && (bus.rsp_len <= 8'(MAX_PAYLOAD_LEN));

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = r_tx_data;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_HDR;
      S_HDR: if (w_loadable) begin
        w_load = 1'b1;
        w_byte = 8'h5A;
        w_next = S_CMD;
      end
      S_CMD: if (w_loadable) begin
        w_load = 1'b1;
        w_byte = r_cmd;
        w_next = S_LEN;
      end
      S_LEN: if (w_loadable) begin
        w_load = 1'b1;
        w_byte = r_len;
        w_next = (r_len == 8'd0) ? S_PAY_END : S_PAY;
      end
      S_PAY: if (w_pay_ready && bus.pay_valid) begin
        w_load = 1'b1;
        w_byte = bus.pay_data;
        if (w_cnt_nxt == r_len) w_next = S_PAY_END;
      end
`ifdef RSP_CHECKSUM_EN
      S_SUM: if (w_loadable) begin
        w_load = 1'b1;
        w_byte = r_sum;
        w_next = S_DONE;
      end
`else
      S_SUM: w_next = S_DONE;
`endif
      // Last byte still sits in the output register until the sink takes it.
      S_DONE: if (r_tx_valid && bus.tx_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'h00;
      r_len       <= 8'h00;
      r_cnt       <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_len_error <= 1'b0;
`ifdef RSP_CHECKSUM_EN
      r_sum       <= 8'h00;
`endif
    end else begin
      r_state     <= w_next;
      r_len_error <= w_reject;
      if (w_accept) begin
        r_cmd <= {bus.rsp_periph, bus.rsp_opcode};
        r_len <= bus.rsp_len;
        r_cnt <= 8'h00;
`ifdef RSP_CHECKSUM_EN
        r_sum <= 8'h00;
`endif
      end
      if (w_load) begin
        r_tx_data  <= w_byte;
        r_tx_valid <= 1'b1;
`ifdef RSP_CHECKSUM_EN
        r_sum      <= r_sum + w_byte;
`endif
      end else if (bus.tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (w_load && (r_state == S_PAY)) r_cnt <= w_cnt_nxt;
    end
  end

  assign bus.rsp_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.pay_ready  = w_pay_ready;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.frame_done = (r_state == S_DONE) && r_tx_valid && bus.tx_ready;
  assign bus.len_error  = r_len_error;
endmodule

// File: tb/tb_response_framer.sv
// Directed bench for response_framer: vector table of whole frames plus stall,
// reject, max-length and mid-frame reset sequences. Honours RSP_CHECKSUM_EN.
module tb_response_framer;
  logic clk, rst_n, pay_clr;
  int   n_checks, n_errs;
  logic [7:0] g_pay [0:79];
  logic [7:0] g_exp [0:79];
  int   g_n, g_nb, g_pidx;

  response_framer_if bus ();
  response_framer #(.MAX_PAYLOAD_LEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.pay_data = g_pay[g_pidx];
  always @(posedge clk) begin
    if (pay_clr) g_pidx <= 0;
    else if (bus.pay_valid && bus.pay_ready) g_pidx <= g_pidx + 1;
  end

  typedef struct {
    logic [2:0]  periph;
    logic [4:0]  opcode;
    logic [7:0]  len;
    logic [31:0] pay;      // byte 0 in [31:24]
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] sum);
    g_exp[0] = 8'h5A;
    g_exp[1] = cmd;
    g_exp[2] = len;
    for (int i = 0; i < int'(len); i++) g_exp[3+i] = g_pay[i];
`ifdef RSP_CHECKSUM_EN
    g_exp[3+int'(len)] = sum;
    g_n = int'(len) + 4;
`else
    g_n = int'(len) + 3;
`endif
    g_nb = 0;
  endtask

  task automatic request(input logic [2:0] p, input logic [4:0] o, input logic [7:0] l);
    @(negedge clk);
    bus.rsp_req = 1'b1;
    bus.rsp_periph = p;
    bus.rsp_opcode = o;
    bus.rsp_len = l;
    pay_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_req = 1'b0;
    pay_clr = 1'b0;
  endtask

  task automatic collect(input string tag, output int cyc);
    bit done;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (g_nb < g_n) check({tag, " byte"}, bus.tx_data, g_exp[g_nb]);
        else check({tag, " extra byte"}, 1, 0);
        g_nb++;
        check({tag, " frame_done"}, bus.frame_done, g_nb == g_n);
        if (bus.frame_done) done = 1'b1;
      end
    end
    if (!done) check({tag, " timeout"}, 0, 1);
    check({tag, " byte count"}, g_nb, g_n);
    @(negedge clk);
    check({tag, " rsp_ready after"}, bus.rsp_ready, 1);
    check({tag, " tx_valid after"}, bus.tx_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    for (int i = 0; i < 4; i++) g_pay[i] = v.pay[31-8*i -: 8];
    set_exp(v.exp_cmd, v.len, v.exp_sum);
    request(v.periph, v.opcode, v.len);
    collect(tag, cyc);
    check({tag, " latency"}, cyc, g_n + 1);
    check({tag, " pay handshakes"}, g_pidx, {24'd0, v.len});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rsp_ready"},  bus.rsp_ready, 1);
    check({tag, " pay_ready"},  bus.pay_ready, 0);
    check({tag, " tx_data"},    bus.tx_data, 0);
    check({tag, " tx_valid"},   bus.tx_valid, 0);
    check({tag, " busy"},       bus.busy, 0);
    check({tag, " frame_done"}, bus.frame_done, 0);
    check({tag, " len_error"},  bus.len_error, 0);
  endtask

  initial begin
    vec_t vecs [4];
    int cyc;
    n_checks = 0; n_errs = 0; g_pidx = 0; g_n = 0; g_nb = 0;
    for (int i = 0; i < 80; i++) begin g_pay[i] = 8'h00; g_exp[i] = 8'h00; end
    vecs[0] = '{3'd1, 5'd2,  8'd2, 32'h1020_0000, 8'h22, 8'hAE};
    vecs[1] = '{3'd3, 5'd3,  8'd0, 32'h0000_0000, 8'h63, 8'hBD};
    vecs[2] = '{3'd0, 5'd1,  8'd2, 32'hFFFF_0000, 8'h01, 8'h5B};
    vecs[3] = '{3'd2, 5'h1F, 8'd3, 32'h0102_0300, 8'h5F, 8'hC2};

    rst_n = 1'b0; pay_clr = 1'b1;
    bus.rsp_req = 1'b0; bus.rsp_periph = 3'd0; bus.rsp_opcode = 5'd0; bus.rsp_len = 8'd0;
    bus.pay_valid = 1'b1; bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1; pay_clr = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Oversize length rejected without any output
    request(3'd1, 5'd2, 8'd65);
    @(negedge clk);
    check("rej len_error", bus.len_error, 1);
    check("rej rsp_ready", bus.rsp_ready, 1);
    check("rej tx_valid", bus.tx_valid, 0);
    check("rej busy", bus.busy, 0);
    @(negedge clk);
    check("rej pulse end", bus.len_error, 0);
    check("rej tx_valid2", bus.tx_valid, 0);

    // Sink stall on the first payload byte
    g_pay[0] = 8'hFF; g_pay[1] = 8'hFF;
    set_exp(8'h01, 8'd2, 8'h5B);
    request(3'd0, 5'd1, 8'd2);
    repeat (5) @(negedge clk);
    check("stall first pay", bus.tx_data, 8'hFF);
    bus.tx_ready = 1'b0;
    #1;
    check("stall pay_ready", bus.pay_ready, 0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall hold data", bus.tx_data, 8'hFF);
      check("stall hold valid", bus.tx_valid, 1);
      check("stall pay_ready", bus.pay_ready, 0);
    end
    bus.tx_ready = 1'b1;
    g_nb = 4;
    collect("stall", cyc);

    // Largest legal payload: 64 bytes of 0x01
    for (int i = 0; i < 64; i++) g_pay[i] = 8'h01;
    set_exp(8'h00, 8'd64, 8'hDA);
    request(3'd0, 5'd0, 8'd64);
    collect("max len", cyc);
    check("max len latency", cyc, g_n + 1);

    // Reset while streaming payload, then a clean frame
    for (int i = 0; i < 4; i++) g_pay[i] = 8'h30 + 8'(i);
    request(3'd2, 5'h1F, 8'd4);
    repeat (5) @(negedge clk);
    check("midrst in pay", bus.tx_data, 8'h30);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    check("midrst frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    run_vec(vecs[0], "post-reset");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
